// File: rtl/fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_op_sequencer
// Multi-cycle issue controller for a combinational single-precision FP ALU.
// One operation is in flight at a time:
//   IDLE -> accept a request and register the operands and control code.
//   EXEC -> hold the ALU inputs for LAT(op) cycles so the ALU paths can be
//           constrained as multicycle paths.
//   RESP -> hold the captured result until the consumer takes it.
// Exception flags from every capture are OR-ed into a sticky fflags register.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             abandon the in-flight op and return to IDLE
//   req_*             request channel (valid/ready, op, operands, tag)
//   alu_control/a/b   registered drive into the ALU
//   alu_result/zero/exc  combinational ALU outputs
//   resp_*            response channel (valid/ready, result, flags, tag, illegal)
//   fflags, fflags_clear  sticky exception flags and their clear strobe
//   busy              high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module fpu_op_sequencer #(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_tag,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [5:0]  alu_exc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic [5:0]  resp_exc,
    output logic [4:0]  resp_tag,
    output logic        resp_illegal,
    output logic [5:0]  fflags,
    input  logic        fflags_clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter preload (LAT - 1) for an op code; a latency of 0 behaves as 1.
    function automatic logic [3:0] lat_minus1(input logic [3:0] op);
        logic [3:0] lat;
        case (op)
            4'b0000, 4'b0001: lat = LAT_ADD[3:0];
            4'b0010:          lat = LAT_MUL[3:0];
            4'b0011:          lat = LAT_DIV[3:0];
            default:          lat = LAT_MISC[3:0];
        endcase
        if (lat == 4'd0) begin
            lat_minus1 = 4'd0;
        end else begin
            lat_minus1 = lat - 4'd1;
        end
    endfunction

    // Only arithmetic ops and code 1000 report exception flags.
    function automatic logic exc_passes(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000: exc_passes = 1'b1;
            default:                                     exc_passes = 1'b0;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  alu_control_r;
    logic [31:0] alu_a_r, alu_b_r;
    logic [4:0]  tag_r;
    logic        resp_valid_r;
    logic [31:0] resp_result_r;
    logic        resp_zero_r;
    logic [5:0]  resp_exc_r;
    logic [4:0]  resp_tag_r;
    logic        resp_illegal_r;
    logic [5:0]  fflags_r;

    logic        accept_s, capture_s, release_s;
    logic        illegal_s;
    logic [5:0]  exc_new_s;
    logic        req_ready_s, busy_s;

    // Handshake strobes; flush suppresses every one of them.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && req_valid && !flush;
        capture_s = (state_r == ST_EXEC) && (cnt_r == 4'd0) && !flush;
        release_s = (state_r == ST_RESP) && resp_ready && !flush;
        illegal_s = (alu_control_r[3:2] == 2'b11);
        exc_new_s = exc_passes(alu_control_r) ? alu_exc : 6'd0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = ST_IDLE;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = req_valid ? ST_EXEC : ST_IDLE;
                ST_EXEC: state_s = (cnt_r == 4'd0) ? ST_RESP : ST_EXEC;
                ST_RESP: state_s = resp_ready ? ST_IDLE : ST_RESP;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        req_ready_s = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_EXEC, ST_RESP: begin
                req_ready_s = 1'b0;
                busy_s      = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
                busy_s      = 1'b1;
            end
        endcase
    end

    // ALU operand/control registers and the latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control_r <= 4'd0;
            alu_a_r       <= 32'd0;
            alu_b_r       <= 32'd0;
            tag_r         <= 5'd0;
            cnt_r         <= 4'd0;
        end else if (accept_s) begin
            alu_control_r <= req_op;
            alu_a_r       <= req_a;
            alu_b_r       <= req_b;
            tag_r         <= req_tag;
            cnt_r         <= lat_minus1(req_op);
        end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0) && !flush) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response capture register and its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r   <= 1'b0;
            resp_result_r  <= 32'd0;
            resp_zero_r    <= 1'b0;
            resp_exc_r     <= 6'd0;
            resp_tag_r     <= 5'd0;
            resp_illegal_r <= 1'b0;
        end else if (capture_s) begin
            resp_valid_r   <= 1'b1;
            // Illegal codes report a forced zero result regardless of the ALU.
            resp_result_r  <= illegal_s ? 32'd0 : alu_result;
            resp_zero_r    <= illegal_s ? 1'b1 : alu_zero;
            resp_exc_r     <= exc_new_s;
            resp_tag_r     <= tag_r;
            resp_illegal_r <= illegal_s;
        end else if (release_s || flush) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Sticky exception flags; a capture's flags survive a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_r <= 6'd0;
        end else if (capture_s) begin
            fflags_r <= (fflags_clear ? 6'd0 : fflags_r) | exc_new_s;
        end else if (fflags_clear) begin
            fflags_r <= 6'd0;
        end
    end

    assign req_ready    = req_ready_s;
    assign busy         = busy_s;
    assign alu_control  = alu_control_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign resp_valid   = resp_valid_r;
    assign resp_result  = resp_result_r;
    assign resp_zero    = resp_zero_r;
    assign resp_exc     = resp_exc_r;
    assign resp_tag     = resp_tag_r;
    assign resp_illegal = resp_illegal_r;
    assign fflags       = fflags_r;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for fpu_op_sequencer. The bench plays the role
// of the ALU by driving hand-computed alu_result/alu_zero/alu_exc values.
// -----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic [5:0]  alu_exc;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [5:0]  resp_exc;
    logic [4:0]  resp_tag;
    logic        resp_illegal;
    logic [5:0]  fflags;
    logic        fflags_clear;
    logic        busy;

    int passed = 0;
    int total  = 0;

    fpu_op_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_exc(alu_exc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_exc(resp_exc),
        .resp_tag(resp_tag), .resp_illegal(resp_illegal),
        .fflags(fflags), .fflags_clear(fflags_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_req(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag);
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Edges after the accept edge until resp_valid is seen; 99 on timeout.
    task automatic wait_resp(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 4'd0;
        req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0; alu_result = 32'd0;
        alu_zero = 1'b0; alu_exc = 6'd0; resp_ready = 1'b0; fflags_clear = 1'b0;
        step(); step();
        rst = 1'b0;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
        total++; if ({alu_control, alu_a, alu_b} !== 68'd0) $display("FAIL reset_alu got %h want 0", {alu_control, alu_a, alu_b}); else passed++;
        total++; if ({resp_result, resp_zero, resp_exc, resp_tag, resp_illegal} !== 45'd0)
            $display("FAIL reset_resp got %h want 0", {resp_result, resp_zero, resp_exc, resp_tag, resp_illegal}); else passed++;
        total++; if (fflags !== 6'd0) $display("FAIL reset_fflags got %b want 0", fflags); else passed++;
    endtask

    task automatic test_add();
        int lat;
        alu_result = 32'h40400000; alu_zero = 1'b0; alu_exc = 6'd0;
        accept_req(4'b0000, 32'h3F800000, 32'h40000000, 5'd3);
        total++; if (req_ready !== 1'b0) $display("FAIL add_ready_drop got %b want 0", req_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL add_busy got %b want 1", busy); else passed++;
        total++; if ({alu_control, alu_a, alu_b} !== {4'b0000, 32'h3F800000, 32'h40000000})
            $display("FAIL add_alu_drive got %h want 03f80000040000000", {alu_control, alu_a, alu_b}); else passed++;
        wait_resp(lat);
        total++; if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else passed++;
        total++; if (resp_result !== 32'h40400000) $display("FAIL add_result got %h want 40400000", resp_result); else passed++;
        total++; if (resp_tag !== 5'd3) $display("FAIL add_tag got %0d want 3", resp_tag); else passed++;
        total++; if (resp_exc !== 6'd0) $display("FAIL add_exc got %b want 000000", resp_exc); else passed++;
        release_resp();
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL add_release got ready=%b valid=%b want 1/0", req_ready, resp_valid); else passed++;
    endtask

    task automatic test_div_flags();
        int lat;
        alu_result = 32'h7F800000; alu_exc = 6'b000001;
        accept_req(4'b0011, 32'h3F800000, 32'h00000000, 5'd9);
        wait_resp(lat);
        total++; if (lat !== 8) $display("FAIL div_latency got %0d want 8", lat); else passed++;
        total++; if (resp_exc !== 6'b000001) $display("FAIL div_exc got %b want 000001", resp_exc); else passed++;
        total++; if (fflags !== 6'b000001) $display("FAIL div_fflags got %b want 000001", fflags); else passed++;
        release_resp();
        alu_result = 32'h40400000; alu_exc = 6'd0;
        accept_req(4'b0000, 32'h3F800000, 32'h40000000, 5'd4);
        wait_resp(lat);
        release_resp();
        total++; if (fflags !== 6'b000001) $display("FAIL div_sticky got %b want 000001", fflags); else passed++;
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
        total++; if (fflags !== 6'd0) $display("FAIL div_clear got %b want 000000", fflags); else passed++;
    endtask

    task automatic test_back_pressure();
        int lat;
        alu_result = 32'h40C00000; alu_exc = 6'd0;
        accept_req(4'b0010, 32'h40000000, 32'h40400000, 5'd7);
        wait_resp(lat);
        total++; if (lat !== 3) $display("FAIL mul_latency got %0d want 3", lat); else passed++;
        alu_result = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (resp_result !== 32'h40C00000 || resp_tag !== 5'd7 || resp_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] got res=%h tag=%0d valid=%b want 40c00000/7/1", i, resp_result, resp_tag, resp_valid); else passed++;
            total++; if (req_ready !== 1'b0 || alu_a !== 32'h40000000)
                $display("FAIL bp_ready[%0d] got ready=%b a=%h want 0/40000000", i, req_ready, alu_a); else passed++;
        end
        release_resp();
        total++; if (req_ready !== 1'b1) $display("FAIL bp_release got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_compare_mask();
        int lat;
        alu_result = 32'h00000001; alu_zero = 1'b0; alu_exc = 6'b111111;
        accept_req(4'b0110, 32'hBF800000, 32'h3F800000, 5'd12);
        wait_resp(lat);
        total++; if (lat !== 1) $display("FAIL clt_latency got %0d want 1", lat); else passed++;
        total++; if (resp_result !== 32'd1) $display("FAIL clt_result got %h want 00000001", resp_result); else passed++;
        total++; if (resp_exc !== 6'd0 || fflags !== 6'd0)
            $display("FAIL clt_mask got exc=%b fflags=%b want 0/0", resp_exc, fflags); else passed++;
        release_resp();
    endtask

    task automatic test_illegal();
        int lat;
        alu_result = 32'h12345678; alu_zero = 1'b0; alu_exc = 6'b100000;
        accept_req(4'b1110, 32'h11111111, 32'h22222222, 5'd20);
        total++; if (alu_control !== 4'b1110) $display("FAIL ill_control got %b want 1110", alu_control); else passed++;
        wait_resp(lat);
        total++; if (lat !== 1) $display("FAIL ill_latency got %0d want 1", lat); else passed++;
        total++; if ({resp_illegal, resp_result, resp_zero, resp_exc} !== {1'b1, 32'd0, 1'b1, 6'd0})
            $display("FAIL ill_resp got ill=%b res=%h zero=%b exc=%b want 1/0/1/0", resp_illegal, resp_result, resp_zero, resp_exc); else passed++;
        release_resp();
    endtask

    task automatic test_lw_mask();
        int lat;
        alu_result = 32'hCAFE0000; alu_zero = 1'b0; alu_exc = 6'b100000;
        accept_req(4'b1000, 32'h00000010, 32'h00000000, 5'd1);
        wait_resp(lat);
        total++; if (resp_exc !== 6'b100000 || fflags !== 6'b100000 || resp_illegal !== 1'b0)
            $display("FAIL lw_pass got exc=%b fflags=%b ill=%b want 100000/100000/0", resp_exc, fflags, resp_illegal); else passed++;
        release_resp();
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        alu_result = 32'h7F800000; alu_exc = 6'b000001;
        accept_req(4'b0011, 32'h3F800000, 32'h00000000, 5'd5);
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL flush_exec got busy=%b ready=%b valid=%b want 0/1/0", busy, req_ready, resp_valid); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL flush_no_resp got %b want 0", seen); else passed++;
        total++; if (fflags !== 6'd0) $display("FAIL flush_fflags got %b want 000000", fflags); else passed++;
        req_op = 4'b0000; req_valid = 1'b1; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_idle got busy=%b ready=%b want 0/1", busy, req_ready); else passed++;
    endtask

    task automatic test_clear_capture();
        int lat;
        alu_result = 32'h0; alu_exc = 6'b100000;
        accept_req(4'b1000, 32'h0, 32'h0, 5'd2);
        wait_resp(lat);
        release_resp();
        total++; if (fflags !== 6'b100000) $display("FAIL cc_pre got %b want 100000", fflags); else passed++;
        alu_result = 32'h7F800000; alu_exc = 6'b000001;
        accept_req(4'b0011, 32'h3F800000, 32'h00000000, 5'd6);
        for (int i = 0; i < 7; i++) step();
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
        total++; if (resp_valid !== 1'b1 || fflags !== 6'b000001)
            $display("FAIL cc_same_cycle got valid=%b fflags=%b want 1/000001", resp_valid, fflags); else passed++;
        release_resp();
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_flags();
        test_back_pressure();
        test_compare_mask();
        test_illegal();
        test_lw_mask();
        test_flush();
        test_clear_capture();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
